lif_array: RTL and testbench



---
 rtl/lif_array.sv | 149 ++++++++++++++
 tb/tb_lif_array.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/lif_array.sv
`default_nettype none
// ============================================================================
// Module      : lif_array
// Description : Array of N leaky integrate-and-fire neurons sharing one clock,
//               one step strobe and one base threshold. Each neuron has a
//               subtractive leak (state >> LEAK_SHIFT), saturating
//               integration, a fixed refractory period and, when the macro
//               LIF_ADAPT_THRESH_EN is defined, a spike-driven adaptive
//               threshold offset.
//
// Ports       : clk       - clock, rising edge
//               rst_n     - asynchronous active-low reset
//               step_en   - advance every neuron by one time step
//               current   - N*W input currents, neuron i at [i*W +: W]
//               thr_base  - shared base firing threshold
//               state     - N*W registered membrane potentials
//               spike     - N registered one-step spike pulses
//               thr       - N*W effective thresholds (combinational)
//               spike_any - registered OR of spike
//
// Config      : LIF_ADAPT_THRESH_EN - compile in the adaptive threshold
// Revision    : 1.0 - initial release
// ============================================================================
module lif_array #(
    parameter int N          = 4,
    parameter int W          = 8,
    parameter int LEAK_SHIFT = 1,
    parameter int REFRAC     = 2,
    parameter int THR_INC    = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           step_en,
    input  logic [N*W-1:0] current,
    input  logic [W-1:0]   thr_base,
    output logic [N*W-1:0] state,
    output logic [N-1:0]   spike,
    output logic [N*W-1:0] thr,
    output logic           spike_any
);

    localparam logic [3:0]   c_refrac = 4'(REFRAC);
    localparam logic [3:0]   c_refr_one = 4'd1;
    localparam logic [W-1:0] c_max = {W{1'b1}};

    // Elaboration-time guard on the parameter ranges the datapath relies on.
    if (LEAK_SHIFT < 1 || LEAK_SHIFT >= W || REFRAC < 0 || REFRAC > 15 ||
        THR_INC < 0) begin : g_param_check
        $error("lif_array: parameter out of range");
    end

    // Per-neuron fire decision for the current step (ignores step_en).
    logic [N-1:0] w_fire;
    logic         r_spike_any;

    for (genvar gi = 0; gi < N; gi++) begin : g_neuron
        logic [W-1:0] r_state;
        logic [3:0]   r_refr;
        logic         r_spike;
        logic [W-1:0] w_off;
        logic [W:0]   w_thr_sum;
        logic [W-1:0] w_thr;
        logic [W-1:0] w_leaked;
        logic [W:0]   w_sum_ext;
        logic [W-1:0] w_sum;

        // Effective threshold saturates rather than wrapping when the
        // offset pushes it past full scale.
        assign w_thr_sum = {1'b0, thr_base} + {1'b0, w_off};
        assign w_thr     = w_thr_sum[W] ? c_max : w_thr_sum[W-1:0];

        // The leaked value never underflows since (x >> k) <= x.
        assign w_leaked  = r_state - (r_state >> LEAK_SHIFT);
        assign w_sum_ext = {1'b0, w_leaked} + {1'b0, current[gi*W +: W]};
        assign w_sum     = w_sum_ext[W] ? c_max : w_sum_ext[W-1:0];

        assign w_fire[gi] = (r_refr == 4'd0) && (w_sum >= w_thr);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state <= '0;
                r_refr  <= '0;
                r_spike <= 1'b0;
            end else if (step_en) begin
                if (r_refr != 4'd0) begin
                    r_state <= '0;
                    r_refr  <= r_refr - c_refr_one;
                    r_spike <= 1'b0;
                end else if (w_fire[gi]) begin
                    r_state <= '0;
                    r_refr  <= c_refrac;
                    r_spike <= 1'b1;
                end else begin
                    r_state <= w_sum;
                    r_spike <= 1'b0;
                end
            end else begin
                // Spike is a one-step pulse; everything else holds.
                r_spike <= 1'b0;
            end
        end

`ifdef LIF_ADAPT_THRESH_EN
        localparam logic [W:0]   c_thr_inc = (W+1)'(THR_INC);
        localparam logic [W-1:0] c_off_one = {{(W-1){1'b0}}, 1'b1};
        logic [W-1:0] r_off;
        logic [W:0]   w_off_inc;

        assign w_off_inc = {1'b0, r_off} + c_thr_inc;

        // Offset jumps up on a spike and decays by one on every other step,
        // refractory steps included.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_off <= '0;
            end else if (step_en) begin
                if (w_fire[gi]) begin
                    r_off <= w_off_inc[W] ? c_max : w_off_inc[W-1:0];
                end else if (r_off != '0) begin
                    r_off <= r_off - c_off_one;
                end
            end
        end

        assign w_off = r_off;
`else
        assign w_off = '0;
`endif

        assign state[gi*W +: W] = r_state;
        assign thr[gi*W +: W]   = w_thr;
        assign spike[gi]        = r_spike;
    end

    // Registered alongside the per-neuron spikes so it is coincident with them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_spike_any <= 1'b0;
        end else if (step_en) begin
            r_spike_any <= |w_fire;
        end else begin
            r_spike_any <= 1'b0;
        end
    end

    assign spike_any = r_spike_any;

endmodule
`default_nettype wire

// File: tb/tb_lif_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_lif_array
// Description : Self-checking bench for lif_array (N=4, W=8, LEAK_SHIFT=1,
//               REFRAC=2). A driver issues directed steps and queues the
//               hand-computed response; a monitor pops and compares on the
//               falling edge after each step. Adaptive-threshold scenario is
//               selected by LIF_ADAPT_THRESH_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lif_array;

    logic        clk;
    logic        rst_n;
    logic        step_en;
    logic [31:0] current;
    logic [7:0]  thr_base;
    logic [31:0] state;
    logic [3:0]  spike;
    logic [31:0] thr;
    logic        spike_any;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] st;
        logic [3:0]  sp;
        logic [31:0] th;
        logic        any;
        string       nm;
    } exp_t;

    exp_t exp_q[$];

    lif_array #(
        .N(4), .W(8), .LEAK_SHIFT(1), .REFRAC(2), .THR_INC(16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .step_en   (step_en),
        .current   (current),
        .thr_base  (thr_base),
        .state     (state),
        .spike     (spike),
        .thr       (thr),
        .spike_any (spike_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    // Apply one cycle of inputs and queue the response expected after it.
    task automatic step(input logic en, input logic [31:0] cur, input logic [7:0] tb_thr,
                        input logic [31:0] e_st, input logic [3:0] e_sp,
                        input logic [31:0] e_th, input string nm);
        exp_t e;
        step_en  = en;
        current  = cur;
        thr_base = tb_thr;
        @(posedge clk);
        e.st  = e_st;
        e.sp  = e_sp;
        e.th  = e_th;
        e.any = (e_sp != 4'd0);
        e.nm  = nm;
        exp_q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    // Asynchronous reset between clock edges, checked before any edge.
    task automatic do_reset(input string nm);
        step_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk({nm, ".state"}, state, 32'd0);
        chk({nm, ".spike"}, {28'd0, spike}, 32'd0);
        chk({nm, ".spike_any"}, {31'd0, spike_any}, 32'd0);
        chk({nm, ".thr"}, thr, {4{thr_base}});
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    // Monitor: compare whenever a step result is due.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk({e.nm, ".state"}, state, e.st);
                chk({e.nm, ".spike"}, {28'd0, spike}, {28'd0, e.sp});
                chk({e.nm, ".thr"}, thr, e.th);
                chk({e.nm, ".spike_any"}, {31'd0, spike_any}, {31'd0, e.any});
            end
        end
    end

    initial begin
        int e0[8] = '{40, 60, 70, 75, 78, 79, 80, 80};
        int e1[8] = '{30, 45, 53, 57, 59, 60, 60, 60};
        int e3[8] = '{10, 15, 18, 19, 20, 20, 20, 20};
        int h0[9] = '{40, 60, 70, 70, 70, 70, 70, 70, 75};

        rst_n    = 1'b0;
        step_en  = 1'b0;
        current  = 32'd0;
        thr_base = 8'd100;
        #12;
        chk("por.state", state, 32'd0);
        chk("por.thr", thr, {4{8'd100}});
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Leak convergence, four channels with distinct currents, no firing.
        for (int k = 0; k < 8; k++) begin
            step(1'b1, {8'd10, 8'd0, 8'd30, 8'd40}, 8'd100,
                 {8'(e3[k]), 8'd0, 8'(e1[k]), 8'(e0[k])}, 4'b0000,
                 {4{8'd100}}, $sformatf("leak%0d", k));
        end
        do_reset("rst_leak");

        // Hold: three steps to 70, five idle cycles with a bogus current, resume.
        for (int k = 0; k < 9; k++) begin
            logic en;
            en = (k < 3 || k == 8);
            step(en, en ? 32'd40 : 32'hFFFF_FFFF, 8'd100,
                 {24'd0, 8'(h0[k])}, 4'b0000, {4{8'd100}}, $sformatf("hold%0d", k));
        end

`ifndef LIF_ADAPT_THRESH_EN
        do_reset("rst_hold");

        // Fire/refractory: ch0=200, ch1=149, ch2=0, ch3=100, threshold 150.
        step(1, {8'd100, 8'd0, 8'd149, 8'd200}, 8'd150, {8'd100, 8'd0, 8'd149, 8'd0}, 4'b0001, {4{8'd150}}, "fire1");
        step(1, {8'd100, 8'd0, 8'd149, 8'd200}, 8'd150, 32'd0, 4'b1010, {4{8'd150}}, "fire2");
        step(1, {8'd100, 8'd0, 8'd149, 8'd200}, 8'd150, 32'd0, 4'b0000, {4{8'd150}}, "fire3");
        step(1, {8'd100, 8'd0, 8'd149, 8'd200}, 8'd150, 32'd0, 4'b0001, {4{8'd150}}, "fire4");
        step(1, {8'd100, 8'd0, 8'd149, 8'd200}, 8'd150, {8'd100, 8'd0, 8'd149, 8'd0}, 4'b0000, {4{8'd150}}, "fire5");
        step(1, {8'd100, 8'd0, 8'd149, 8'd200}, 8'd150, 32'd0, 4'b1010, {4{8'd150}}, "fire6");
        step(1, {8'd100, 8'd0, 8'd149, 8'd200}, 8'd150, 32'd0, 4'b0001, {4{8'd150}}, "fire7");
        // Spike and spike_any are high here; reset must clear them at once.
        do_reset("rst_fire");

        // Saturation at threshold 255: ch0=200, ch1=255, ch2=128, ch3=0.
        step(1, {8'd0, 8'd128, 8'd255, 8'd200}, 8'd255, {8'd0, 8'd128, 8'd0, 8'd200}, 4'b0010, {4{8'd255}}, "sat1");
        step(1, {8'd0, 8'd128, 8'd255, 8'd200}, 8'd255, {8'd0, 8'd192, 8'd0, 8'd0}, 4'b0001, {4{8'd255}}, "sat2");
        step(1, {8'd0, 8'd128, 8'd255, 8'd200}, 8'd255, {8'd0, 8'd224, 8'd0, 8'd0}, 4'b0000, {4{8'd255}}, "sat3");
        step(1, {8'd0, 8'd128, 8'd255, 8'd200}, 8'd255, {8'd0, 8'd240, 8'd0, 8'd0}, 4'b0010, {4{8'd255}}, "sat4");
        do_reset("rst_sat");

        // Zero threshold: every non-refractory step fires even with no input.
        step(1, 32'd0, 8'd0, 32'd0, 4'b1111, 32'd0, "thr0_1");
        step(1, 32'd0, 8'd0, 32'd0, 4'b0000, 32'd0, "thr0_2");
        step(1, 32'd0, 8'd0, 32'd0, 4'b0000, 32'd0, "thr0_3");
        step(1, 32'd0, 8'd0, 32'd0, 4'b1111, 32'd0, "thr0_4");

        // thr follows thr_base combinationally.
        step_en  = 1'b0;
        thr_base = 8'd77;
        #1;
        chk("thr_comb", thr, {4{8'd77}});
`else
        do_reset("rst_hold");

        // Adaptive threshold on channel 0 only.
        step(1, 32'd200, 8'd150, 32'd0, 4'b0001, {8'd150, 8'd150, 8'd150, 8'd166}, "adapt1");
        step(1, 32'd200, 8'd150, 32'd0, 4'b0000, {8'd150, 8'd150, 8'd150, 8'd165}, "adapt2");
        step(1, 32'd200, 8'd150, 32'd0, 4'b0000, {8'd150, 8'd150, 8'd150, 8'd164}, "adapt3");
        step(1, 32'd200, 8'd150, 32'd0, 4'b0001, {8'd150, 8'd150, 8'd150, 8'd180}, "adapt4");
        // Idle cycle: offset holds at 30.
        step(0, 32'd200, 8'd150, 32'd0, 4'b0000, {8'd150, 8'd150, 8'd150, 8'd180}, "adapt_hold");

        step_en  = 1'b0;
        thr_base = 8'd77;
        #1;
        chk("thr_comb", thr, {8'd77, 8'd77, 8'd77, 8'd107});
        do_reset("rst_adapt");
`endif

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        chk("drain", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
